// File: rtl/buf_executor_pkg.sv
// Shared definitions for the buffered micro-sequencer: buffer geometry, opcodes,
// error codes and FSM state encoding.
package buf_executor_pkg;

  localparam int unsigned DEPTH     = 512;
  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam logic [15:0] DEPTH_LIM = 16'(DEPTH);

  // Register-write opcodes are 01aaaaaa; only the top two bits identify them.
  localparam logic [1:0] OP_WREG = 2'b01;
  localparam logic [7:0] OP_NOP  = 8'h80;
  localparam logic [7:0] OP_STB  = 8'h81;
  localparam logic [7:0] OP_WAIT = 8'h82;
  localparam logic [7:0] OP_JUMP = 8'h83;
  localparam logic [7:0] OP_HALT = 8'hBF;

  localparam logic [7:0] E_NONE  = 8'd0;
  localparam logic [7:0] E_OPC   = 8'd1;
  localparam logic [7:0] E_RANGE = 8'd2;
  localparam logic [7:0] E_ABORT = 8'd3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StWaitReg,
    StWaitInt
  } state_e;

  function automatic logic is_wreg(input logic [7:0] op);
    return op[7:6] == OP_WREG;
  endfunction

endpackage

// File: rtl/buf_executor_if.sv
// Register-write bus and host buffer-load bus between s3g_executor and the sequencer.
interface buf_executor_if;

  logic [5:0]  ext_out_reg_addr;
  logic [31:0] ext_out_reg_data;
  logic        ext_out_reg_stb;
  logic        ext_out_reg_busy;
  logic [15:0] ext_buffer_addr;
  logic [39:0] ext_buffer_data;
  logic        ext_buffer_wr;

  modport master (
    output ext_buffer_addr, ext_buffer_data, ext_buffer_wr, ext_out_reg_busy,
    input  ext_out_reg_addr, ext_out_reg_data, ext_out_reg_stb
  );

  modport slave (
    input  ext_buffer_addr, ext_buffer_data, ext_buffer_wr, ext_out_reg_busy,
    output ext_out_reg_addr, ext_out_reg_data, ext_out_reg_stb
  );

endinterface

// File: rtl/buf_ram.sv
// Simple dual-port instruction buffer with registered read, shaped for block RAM.
module buf_ram #(
  parameter int unsigned Depth = 512,
  parameter int unsigned Width = 40,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/buf_executor.sv
// Micro-sequencer that runs a host-loaded instruction buffer, issuing register
// writes and strobes into s3g_executor and waiting on its interrupt lines.
module buf_executor
  import buf_executor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  buf_executor_if.slave       bus,
  output logic [15:0]         pc,
  output logic [7:0]          error,
  input  logic                start,
  input  logic [15:0]         start_addr,
  output logic                done,
  input  logic                abort,
  output logic                load,
  output logic                complete,
  input  logic [31:0]         ext_pending_ints,
  output logic [31:0]         ext_clear_ints,
  output logic [31:0]         ext_out_stbs
);

  state_e      state_q;
  logic [15:0] pc_q;
  logic [7:0]  err_q;
  logic        done_q, load_q, complete_q, stb_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q, stbs_q, clr_q, mask_q;
  logic [39:0] word;
  logic [7:0]  op;
  logic [31:0] arg;
  logic [31:0] hit;
  logic        wr_en;

  assign wr_en = bus.ext_buffer_wr && (bus.ext_buffer_addr < DEPTH_LIM);

  buf_ram #(
    .Depth (DEPTH),
    .Width (40)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.ext_buffer_addr[ADDR_W-1:0]),
    .wr_data_i (bus.ext_buffer_data),
    .rd_addr_i (pc_q[ADDR_W-1:0]),
    .rd_data_o (word)
  );

  assign op  = word[39:32];
  assign arg = word[31:0];
  assign hit = ext_pending_ints & mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      err_q      <= E_NONE;
      done_q     <= 1'b1;
      load_q     <= 1'b0;
      complete_q <= 1'b0;
      stb_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      stbs_q     <= '0;
      clr_q      <= '0;
      mask_q     <= '0;
    end else begin
      load_q     <= 1'b0;
      complete_q <= 1'b0;
      stb_q      <= 1'b0;
      stbs_q     <= '0;
      clr_q      <= '0;
      // Abort preempts whatever the running state would have issued this cycle.
      if (state_q != StIdle && abort) begin
        state_q    <= StIdle;
        err_q      <= E_ABORT;
        done_q     <= 1'b1;
        complete_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              pc_q <= start_addr;
              if (start_addr >= DEPTH_LIM) begin
                err_q      <= E_RANGE;
                complete_q <= 1'b1;
              end else begin
                err_q   <= E_NONE;
                done_q  <= 1'b0;
                state_q <= StFetch;
              end
            end
          end
          StFetch: begin
            if (pc_q >= DEPTH_LIM) begin
              state_q    <= StIdle;
              err_q      <= E_RANGE;
              done_q     <= 1'b1;
              complete_q <= 1'b1;
            end else begin
              load_q  <= 1'b1;
              state_q <= StExec;
            end
          end
          StExec: begin
            if (is_wreg(op)) begin
              addr_q <= op[5:0];
              data_q <= arg;
              if (!bus.ext_out_reg_busy) begin
                stb_q   <= 1'b1;
                pc_q    <= pc_q + 16'd1;
                state_q <= StFetch;
              end else begin
                state_q <= StWaitReg;
              end
            end else begin
              unique case (op)
                OP_NOP: begin
                  pc_q    <= pc_q + 16'd1;
                  state_q <= StFetch;
                end
                OP_STB: begin
                  stbs_q  <= arg;
                  pc_q    <= pc_q + 16'd1;
                  state_q <= StFetch;
                end
                OP_WAIT: begin
                  mask_q  <= arg;
                  state_q <= StWaitInt;
                end
                OP_JUMP: begin
                  pc_q    <= arg[15:0];
                  state_q <= StFetch;
                end
                OP_HALT: begin
                  state_q    <= StIdle;
                  err_q      <= E_NONE;
                  done_q     <= 1'b1;
                  complete_q <= 1'b1;
                end
                default: begin
                  state_q    <= StIdle;
                  err_q      <= E_OPC;
                  done_q     <= 1'b1;
                  complete_q <= 1'b1;
                end
              endcase
            end
          end
          StWaitReg: begin
            if (!bus.ext_out_reg_busy) begin
              stb_q   <= 1'b1;
              pc_q    <= pc_q + 16'd1;
              state_q <= StFetch;
            end
          end
          StWaitInt: begin
            if (hit != '0) begin
              clr_q   <= hit;
              pc_q    <= pc_q + 16'd1;
              state_q <= StFetch;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign pc                   = pc_q;
  assign error                = err_q;
  assign done                 = done_q;
  assign load                 = load_q;
  assign complete             = complete_q;
  assign ext_clear_ints       = clr_q;
  assign ext_out_stbs         = stbs_q;
  assign bus.ext_out_reg_addr = addr_q;
  assign bus.ext_out_reg_data = data_q;
  assign bus.ext_out_reg_stb  = stb_q;

endmodule

// File: tb/tb_buf_executor.sv
// Scoreboard bench for buf_executor: stimulus queues expected events, a monitor pops them.
module tb_buf_executor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [7:0]  error;
  logic        start;
  logic [15:0] start_addr;
  logic        done;
  logic        abort;
  logic        load;
  logic        complete;
  logic [31:0] pending;
  logic [31:0] clear_ints;
  logic [31:0] out_stbs;

  buf_executor_if bus_if ();

  buf_executor dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus_if),
    .pc               (pc),
    .error            (error),
    .start            (start),
    .start_addr       (start_addr),
    .done             (done),
    .abort            (abort),
    .load             (load),
    .complete         (complete),
    .ext_pending_ints (pending),
    .ext_clear_ints   (clear_ints),
    .ext_out_stbs     (out_stbs)
  );

  always #5 clk = ~clk;

  typedef enum int {EvReg, EvStbs, EvClr, EvDone} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] a;
    logic [31:0] b;
    bit          chk_a;
  } ev_t;

  ev_t   exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    load_cnt = 0;
  string cur_test = "reset";
  logic  prev_complete = 1'b0;

  task automatic push(input kind_e k, input logic [31:0] a, input logic [31:0] b,
                      input bit chk_a);
    ev_t e;
    e.kind  = k;
    e.a     = a;
    e.b     = b;
    e.chk_a = chk_a;
    exp_q.push_back(e);
  endtask

  // Completion events carry pc in a and {error, done} in b.
  task automatic push_done(input logic [15:0] p, input logic [7:0] err, input bit chk_pc);
    push(EvDone, {16'h0, p}, {23'h0, err, 1'b1}, chk_pc);
  endtask

  task automatic observe(input kind_e k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected_%s: got a=%h b=%h, required no event",
               cur_test, k.name(), a, b);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || (e.chk_a && e.a != a) || e.b != b) begin
      n_fail++;
      $display("FAIL %s event: got %s a=%h b=%h, required %s a=%h b=%h",
               cur_test, k.name(), a, b, e.kind.name(), e.a, e.b);
    end
  endtask

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s %s: got %h, required %h", cur_test, name, got, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.ext_out_reg_stb) begin
        observe(EvReg, {26'h0, bus_if.ext_out_reg_addr}, bus_if.ext_out_reg_data);
        if (bus_if.ext_out_reg_busy) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s stb_while_busy: got stb=1 busy=1, required stb=0", cur_test);
        end
      end
      if (out_stbs != '0)   observe(EvStbs, out_stbs, 32'h0);
      if (clear_ints != '0) observe(EvClr, clear_ints, 32'h0);
      if (complete)         observe(EvDone, {16'h0, pc}, {23'h0, error, done});
      if (complete && prev_complete) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s complete_width: got 2+ cycles, required 1", cur_test);
      end
      if (load) load_cnt++;
      prev_complete <= complete;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [39:0] d);
    bus_if.ext_buffer_addr = a;
    bus_if.ext_buffer_data = d;
    bus_if.ext_buffer_wr   = 1'b1;
    tick(1);
    bus_if.ext_buffer_wr   = 1'b0;
  endtask

  task automatic run(input logic [15:0] a, input logic with_abort);
    start_addr = a;
    start      = 1'b1;
    abort      = with_abort;
    tick(1);
    start      = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 400) begin
      tick(1);
      i++;
    end
    tick(6);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_prog;
    wr_word(16'h0110, 40'h4E04030201);
    wr_word(16'h0111, 40'h4D14131211);
    wr_word(16'h0112, 40'h8108080404);
    wr_word(16'h0113, 40'hBF00000000);
  endtask

  task automatic push_prog;
    push(EvReg, 32'd14, 32'h04030201, 1'b1);
    push(EvReg, 32'd13, 32'h14131211, 1'b1);
    push(EvStbs, 32'h08080404, 32'h0, 1'b1);
    push_done(16'h0113, 8'd0, 1'b1);
  endtask

  initial begin
    rst                     = 1'b1;
    start                   = 1'b0;
    start_addr              = '0;
    abort                   = 1'b0;
    pending                 = '0;
    bus_if.ext_out_reg_busy = 1'b0;
    bus_if.ext_buffer_addr  = '0;
    bus_if.ext_buffer_data  = '0;
    bus_if.ext_buffer_wr    = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("pc", {24'h0, pc}, 40'h0);
    check("error", {32'h0, error}, 40'h0);
    check("done", {39'h0, done}, 40'h1);
    check("pulses", {37'h0, load, complete, bus_if.ext_out_reg_stb}, 40'h0);
    check("stbs_clr", {8'h0, out_stbs | clear_ints}, 40'h0);
    check("reg_addr_data", {2'h0, bus_if.ext_out_reg_addr, bus_if.ext_out_reg_data}, 40'h0);
    tick(1);

    cur_test = "basic";
    set_prog();
    push_prog();
    load_cnt = 0;
    run(16'h0110, 1'b0);
    check("done_running", {39'h0, done}, 40'h0);
    drain(cur_test);
    check("loads", 40'(load_cnt), 40'd4);

    cur_test = "busy";
    bus_if.ext_out_reg_busy = 1'b1;
    push_prog();
    run(16'h0110, 1'b0);
    tick(10);
    bus_if.ext_out_reg_busy = 1'b0;
    drain(cur_test);

    cur_test = "wait_int";
    wr_word(16'h0000, 40'h8200004000);
    wr_word(16'h0001, 40'hBF00000000);
    push(EvClr, 32'h00004000, 32'h0, 1'b1);
    push_done(16'h0001, 8'd0, 1'b1);
    run(16'h0000, 1'b0);
    tick(20);
    pending = 32'h0000_4001;
    drain(cur_test);
    pending = '0;

    cur_test = "illegal";
    wr_word(16'h0020, 40'h8000000000);
    wr_word(16'h0021, 40'h0000000000);
    push_done(16'h0021, 8'd1, 1'b1);
    run(16'h0020, 1'b0);
    drain(cur_test);

    cur_test = "jump";
    wr_word(16'h0040, 40'h8300000050);
    wr_word(16'h0050, 40'hBF00000000);
    push_done(16'h0050, 8'd0, 1'b1);
    run(16'h0040, 1'b0);
    drain(cur_test);

    cur_test = "abort";
    wr_word(16'h0030, 40'h8200000001);
    push_done(16'h0030, 8'd3, 1'b1);
    run(16'h0030, 1'b0);
    tick(10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    drain(cur_test);

    cur_test = "pc_wrap";
    wr_word(16'h01FF, 40'h8000000000);
    push_done(16'h0200, 8'd2, 1'b1);
    run(16'h01FF, 1'b0);
    drain(cur_test);

    cur_test = "bad_start";
    push_done(16'h0250, 8'd2, 1'b0);
    run(16'h0250, 1'b0);
    drain(cur_test);

    cur_test = "host_oob";
    wr_word(16'h0100, 40'hBF00000000);
    wr_word(16'h0300, 40'h0000000000);
    push_done(16'h0100, 8'd0, 1'b1);
    run(16'h0100, 1'b0);
    drain(cur_test);

    cur_test = "start_abort";
    push_done(16'h0113, 8'd0, 1'b1);
    run(16'h0113, 1'b1);
    drain(cur_test);

    cur_test = "idle_abort";
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    drain(cur_test);
    check("error_kept", {32'h0, error}, 40'h0);
    check("done_kept", {39'h0, done}, 40'h1);

    cur_test = "rst_mid";
    run(16'h0030, 1'b0);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("done", {39'h0, done}, 40'h1);
    check("error", {32'h0, error}, 40'h0);
    check("pc", {24'h0, pc}, 40'h0);
    drain(cur_test);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
